// File: rtl/ysyx_25070198_sbus_arbiter.sv
// ysyx_25070198_sbus_arbiter: N-master round-robin SimpleBus arbiter, one outstanding transaction; define SBUS_ARB_TIMEOUT_EN for a slave watchdog
module ysyx_25070198_sbus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  localparam int MASK_W = DATA_W / 8,
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_reqValid,
  output logic [N_MASTERS-1:0]          m_reqReady,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_wen,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*MASK_W-1:0]   m_wmask,
  output logic [N_MASTERS-1:0]          m_respValid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_respErr,
  output logic                          s_reqValid,
  input  logic                          s_reqReady,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_wen,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [MASK_W-1:0]             s_wmask,
  input  logic                          s_respValid,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_respErr,
  output logic                          busy,
  output logic [IW-1:0]                 grant_id
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, gnt, idx, nxt;
  logic any, done, tmo;
  // round-robin pick: scanning downward lets the last hit be the first requester at or after rr_ptr
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N_MASTERS);
      if (m_reqValid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  assign nxt = (grant_id == IW'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;
  assign done = (state == WAIT) && s_respValid;
  assign busy = state != IDLE;
  assign s_reqValid = state == REQ;
  assign m_reqReady = (state == IDLE && any && !rst) ? N_MASTERS'(1) << gnt : '0;
`ifdef SBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // watchdog held at zero while idle so it starts counting on entry to REQ
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
  assign tmo = busy && cnt == CW'(TIMEOUT) && !done;
`else
  assign tmo = TIMEOUT < 0;
`endif
  // transaction FSM: grant and latch, present to slave, return registered response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      s_addr <= '0;
      s_wen <= 1'b0;
      s_wdata <= '0;
      s_wmask <= '0;
      m_respValid <= '0;
      m_rdata <= '0;
      m_respErr <= 1'b0;
    end else begin
      m_respValid <= '0;
      if (state == IDLE && any) begin
        state <= REQ;
        grant_id <= gnt;
        s_addr <= m_addr[gnt*ADDR_W +: ADDR_W];
        s_wen <= m_wen[gnt];
        s_wdata <= m_wdata[gnt*DATA_W +: DATA_W];
        s_wmask <= m_wmask[gnt*MASK_W +: MASK_W];
      end else if (state == REQ && s_reqReady) state <= WAIT;
      if (done || tmo) begin
        state <= IDLE;
        rr_ptr <= nxt;
        m_respValid <= N_MASTERS'(1) << grant_id;
        m_rdata <= (done && !s_wen) ? s_rdata : '0;
        m_respErr <= done ? s_respErr : 1'b1;
      end
    end
endmodule
